kernel_stream_loader: RTL and testbench
=======================================

# kernel_stream_loader

Parametrised, read-only AXI4 master that streams convolution-kernel coefficients from DDR into `NUM_CH` downstream kernel FIFOs. It sits between the parameter fetcher, which supplies per-channel address windows, and the kernel FIFOs. Channels are served in round-robin order with one burst in flight at a time. A channel is served only when its FIFO can absorb a whole burst. Each channel's address window either wraps or terminates.

## Interface
- `NUM_CH`, 3, number of kernel channels (1..8)
- `ID_W`, 3, AXI ID width
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 64, AXI data width (power of two, ≥32)
- `BURST_LEN`, 8, beats per burst (1..256)
- `FIFO_DEPTH`, 256, depth of each downstream FIFO in words
- `CNT_W`, $clog2(FIFO_DEPTH)+1, FIFO occupancy width
- `AR_ID`, 1, constant ARID
- `clk`  in  1  clock
- `reset_n`  in  1  reset; synchronous, active-low
- `start`  in  1  one-cycle pulse; loads windows, clears done/error
- `ch_en`  in  NUM_CH  per-channel enable; a cleared bit means the channel is skipped
- `ch_wrap_en`  in  NUM_CH  per-channel wrap enable
- `ch_start_addr`  in  NUM_CH*ADDR_W  window start (inclusive), channel i at [i*ADDR_W +: ADDR_W]
- `ch_end_addr`  in  NUM_CH*ADDR_W  window end (exclusive)
- `fifo_count`  in  NUM_CH*CNT_W  downstream FIFO occupancy
- `fifo_wr_data`  out  DATA_W  registered read data
- `fifo_wr_en`  out  NUM_CH  one-hot write strobe
- `ch_done`  out  NUM_CH  channel window exhausted (non-wrap only)
- `all_done`  out  1  every enabled channel has `ch_done` set
- `busy`  out  1  FSM not in IDLE
- `rd_err`  out  1  sticky; set when RRESP≠OKAY
- `m_axi_ar*`  out  id/addr/len/size/burst/lock/cache/prot/qos/valid  read address channel
- `m_axi_arready`  in  1
- `m_axi_rid`, `m_axi_rdata`, `m_axi_rresp`, `m_axi_rlast`, `m_axi_rvalid`  in  read data channel
- `m_axi_rready`  out  1

## Operation
- Constants: BYTES = BURST_LEN*DATA_W/8; ARLEN = BURST_LEN-1; ARSIZE = log2(DATA_W/8); ARBURST = INCR; ARCACHE = 4'b0011; ARLOCK, ARPROT, ARQOS = 0.
- Address rules: start and end addresses are BYTES-aligned, so a burst never crosses its window. BYTES must be ≤4096.
- FSM: IDLE → SELECT → ADDR → DATA → SETTLE → SELECT.
  - IDLE: waits for `start`.
  - SELECT: a channel is eligible when `ch_en`=1, `ch_done`=0, and FIFO_DEPTH−`fifo_count` ≥ BURST_LEN. The search order begins at last-served+1 (modulo NUM_CH). If a channel is eligible, latch it and go to ADDR. If every enabled channel is done, go to IDLE. Otherwise stay in SELECT.
  - ADDR: `arvalid`=1, `araddr` = channel pointer. On `arready`, advance the pointer and go to DATA.
  - DATA: `rready`=1. Each beat with `rvalid`&`rready` produces a write to the latched channel. On `rlast`, go to SETTLE.
  - SETTLE: one cycle, so that `fifo_count` reflects the final write before the next eligibility check.
- Pointer update at AR handshake: next = ptr+BYTES.
  - If next ≥ end and `ch_wrap_en`: ptr ← start.
  - If next ≥ end and not `ch_wrap_en`: `ch_done` is set.
  - Otherwise: ptr ← next.
- Degenerate window: at `start`, any channel with start ≥ end sets `ch_done` immediately.
- Errors: a beat with RRESP≠0 is still written to the FIFO and sets `rd_err`. RID is ignored.
- `start` while in ADDR or DATA: the request is held pending. AXI rules are honoured: `arvalid` is kept until accepted and the burst is drained with `rready`=1. While draining, `fifo_wr_en` is suppressed. The pending start is applied when the FSM reaches SETTLE, which then reloads all channels and goes to SELECT.
- `start` while in IDLE, SELECT or SETTLE takes effect the next cycle.
- `ch_en` is sampled only in SELECT.

## Timing
- Reset values: every output is 0, `araddr`=0, pointers=0, last-served = NUM_CH−1, FSM=IDLE.
- Reset mid-burst aborts immediately. The interconnect is reset together with this block.
- `start` → `arvalid` is at least 2 cycles (IDLE→SELECT→ADDR).
- An R beat at cycle t produces `fifo_wr_data`/`fifo_wr_en` at t+1.
- Burst-to-burst gap is ≥3 cycles after `rlast` (SETTLE, SELECT, then ADDR).
- `fifo_count` must reflect a write within 1 cycle of that write.

## Structure
- Package `kernel_loader_pkg` holds the FSM state enum, AXI burst/size/cache constants, and the BYTES function.
- Sub-module `rr_arbiter`: NUM_CH request vector plus last-grant in, one-hot grant plus valid out, purely combinational. The loader registers the grant.

## Test plan
- NUM_CH=3, all enabled, windows 0x1000–0x1080 / 0x2000–0x2040 / 0x3000–0x3040, no wrap, slave with zero wait → ARADDR sequence 1000, 2000, 3000, 1040; `all_done` after 4 bursts; 32 writes total, each one-hot to the correct channel.
- `ch_en`=3'b101 → channel 1 is never addressed; grant order is 0, 2, 0, 2.
- `fifo_count[0]`=250 (space 6 < 8) → channel 0 is skipped until the count drops to 248, then it is served.
- Wrap on channel 0, window 0x1000–0x1080 → ARADDR 1000, 1040, 1000; `ch_done[0]` stays 0.
- `start` pulse during DATA beat 3 with `rvalid` stalls → burst drains with no `fifo_wr_en`; next ARADDR equals the reloaded start address.
- RRESP=SLVERR on beat 5 → data is written, `rd_err`=1 until the next `start`; `reset_n`=0 mid-burst → all outputs 0 the next cycle.

Source files
------------

// File: rtl/kernel_loader_pkg.sv
// Shared types and AXI constants for the kernel stream loader.
package kernel_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ADDR,
    S_DATA,
    S_SETTLE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int burst_bytes(input int burst_len, input int data_w);
    return burst_len * data_w / 8;
  endfunction

  function automatic int axi_size(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module rr_arbiter #(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [NUM_CH-1:0] grant,
  output logic              valid
);

  // Two passes: indices above last first, then wrap around to the low ones.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (!valid && req[i] && i > int'(last)) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    for (int i = 0; i < NUM_CH; i++)
      if (!valid && req[i] && i <= int'(last)) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
  end

endmodule

// File: rtl/kernel_stream_loader.sv
// Read-only AXI4 master streaming kernel coefficients into NUM_CH FIFOs,
// one burst in flight, channels served round-robin.
module kernel_stream_loader
  import kernel_loader_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int ID_W       = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 256,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1,
  parameter int AR_ID      = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        ch_wrap_en,
  input  logic [NUM_CH*ADDR_W-1:0] ch_start_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_end_addr,
  input  logic [NUM_CH*CNT_W-1:0]  fifo_count,
  output logic [DATA_W-1:0]        fifo_wr_data,
  output logic [NUM_CH-1:0]        fifo_wr_en,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     all_done,
  output logic                     busy,
  output logic                     rd_err,
  output logic [ID_W-1:0]          m_axi_arid,
  output logic [ADDR_W-1:0]        m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arlock,
  output logic [3:0]               m_axi_arcache,
  output logic [2:0]               m_axi_arprot,
  output logic [3:0]               m_axi_arqos,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [ID_W-1:0]          m_axi_rid,
  input  logic [DATA_W-1:0]        m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(burst_bytes(BURST_LEN, DATA_W));

  state_t state, state_nxt;
  logic [NUM_CH-1:0][ADDR_W-1:0] ptr, win_lo, win_hi;
  logic [IDX_W-1:0]  cur, last_srv, gnt_idx;
  logic [NUM_CH-1:0] req, gnt;
  logic [ADDR_W-1:0] araddr_q, nxt;
  logic gnt_vld, all_fin, beat, reload, start_pend;
  logic unused_rid;

  assign unused_rid   = ^m_axi_rid;
  assign busy         = (state != S_IDLE);
  assign m_axi_arvalid = (state == S_ADDR);
  assign m_axi_rready  = (state == S_DATA);
  assign beat          = m_axi_rvalid && m_axi_rready;
  assign all_fin       = &(ch_done | ~ch_en);
  assign nxt           = ptr[cur] + BYTES_A;

  // Constant AR fields only show while a request is presented, so the bus idles at zero.
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arid    = m_axi_arvalid ? ID_W'(AR_ID) : '0;
  assign m_axi_arlen   = m_axi_arvalid ? 8'(BURST_LEN - 1) : '0;
  assign m_axi_arsize  = m_axi_arvalid ? 3'(axi_size(DATA_W)) : '0;
  assign m_axi_arburst = m_axi_arvalid ? AXI_BURST_INCR : '0;
  assign m_axi_arcache = m_axi_arvalid ? AXI_CACHE_MOD : '0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arprot  = '0;
  assign m_axi_arqos   = '0;

  // A start arriving mid-transaction is deferred to SETTLE so the AXI burst completes cleanly.
  assign reload = (start && (state == S_IDLE || state == S_SELECT || state == S_SETTLE)) ||
                  (start_pend && state == S_SETTLE);

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CH; i++)
      req[i] = ch_en[i] && !ch_done[i] &&
               (32'(fifo_count[i*CNT_W +: CNT_W]) + 32'(BURST_LEN) <= 32'(FIFO_DEPTH));
  end

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .last  (last_srv),
    .grant (gnt),
    .valid (gnt_vld)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt[i]) gnt_idx = IDX_W'(i);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SELECT;
      S_SELECT: if (start)        state_nxt = S_SELECT;
                else if (gnt_vld) state_nxt = S_ADDR;
                else if (all_fin) state_nxt = S_IDLE;
      S_ADDR:   if (m_axi_arready) state_nxt = S_DATA;
      S_DATA:   if (beat && m_axi_rlast) state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_SELECT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0; win_lo <= '0; win_hi <= '0;
      ch_done <= '0; all_done <= 1'b0; rd_err <= 1'b0; start_pend <= 1'b0;
      cur <= '0; last_srv <= IDX_W'(NUM_CH - 1); araddr_q <= '0;
      fifo_wr_en <= '0; fifo_wr_data <= '0;
    end else begin
      fifo_wr_en <= '0;
      if (reload) begin
        win_lo <= ch_start_addr;
        win_hi <= ch_end_addr;
        ptr    <= ch_start_addr;
        for (int i = 0; i < NUM_CH; i++)
          ch_done[i] <= ch_start_addr[i*ADDR_W +: ADDR_W] >= ch_end_addr[i*ADDR_W +: ADDR_W];
        all_done   <= 1'b0;
        rd_err     <= 1'b0;
        start_pend <= 1'b0;
      end
      case (state)
        S_SELECT: if (!start) begin
          if (gnt_vld) begin
            cur      <= gnt_idx;
            last_srv <= gnt_idx;
            araddr_q <= ptr[gnt_idx];
          end else if (all_fin) all_done <= 1'b1;
        end
        S_ADDR: begin
          if (start) start_pend <= 1'b1;
          if (m_axi_arready) begin
            if (nxt >= win_hi[cur]) begin
              if (ch_wrap_en[cur]) ptr[cur] <= win_lo[cur];
              else                 ch_done[cur] <= 1'b1;
            end else ptr[cur] <= nxt;
          end
        end
        S_DATA: begin
          if (start) start_pend <= 1'b1;
          if (beat) begin
            fifo_wr_data <= m_axi_rdata;
            if (!(start || start_pend)) fifo_wr_en <= NUM_CH'(1) << cur;
            if (m_axi_rresp != AXI_RESP_OKAY) rd_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_stream_loader.sv
// Directed bench for kernel_stream_loader with a zero-wait AXI read slave model.
module tb_kernel_stream_loader;
  localparam int NC = 3, AW = 32, DW = 64, BL = 8, CW = 9, IW = 3;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]    ch_en = '0, ch_wrap_en = '0;
  logic [NC*AW-1:0] ch_start_addr = '0, ch_end_addr = '0;
  logic [NC*CW-1:0] fifo_count = '0;
  logic [DW-1:0]    fifo_wr_data;
  logic [NC-1:0]    fifo_wr_en, ch_done;
  logic             all_done, busy, rd_err;
  logic [IW-1:0]    arid, rid = '0;
  logic [AW-1:0]    araddr;
  logic [7:0]       arlen;
  logic [2:0]       arsize, arprot;
  logic [1:0]       arburst, rresp = '0;
  logic             arlock, arvalid, rready, arready = 1'b1, rlast = 1'b0, rvalid = 1'b0;
  logic [3:0]       arcache, arqos;
  logic [DW-1:0]    rdata = '0;

  kernel_stream_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ch_en(ch_en), .ch_wrap_en(ch_wrap_en),
    .ch_start_addr(ch_start_addr), .ch_end_addr(ch_end_addr), .fifo_count(fifo_count),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .ch_done(ch_done),
    .all_done(all_done), .busy(busy), .rd_err(rd_err),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int checks = 0, errors = 0;
  int n_ar = 0, n_wr = 0, bad_onehot = 0;
  int wr_cnt [NC];
  logic [AW-1:0] ar_log [16];
  logic [DW-1:0] data_log [64];
  int ch_log [64];

  // Slave: decides at each falling edge what the DUT samples on the next rising edge.
  int s_beat = 0, hold_at = -1, err_beat = -1;
  bit s_active = 0, ar_fire = 0, r_fire = 0;
  logic [AW-1:0] s_addr = '0, ar_addr_q = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      s_active = 0; s_beat = 0; ar_fire = 0; r_fire = 0;
      rvalid = 0; rlast = 0; rresp = '0; rdata = '0;
    end else begin
      if (r_fire) begin s_beat++; if (s_beat == BL) s_active = 0; end
      if (ar_fire) begin s_active = 1; s_beat = 0; s_addr = ar_addr_q; end
      rvalid = s_active && (s_beat != hold_at);
      rlast  = s_active && (s_beat == BL - 1);
      rdata  = {32'h0, s_addr} + 64'(s_beat * 8);
      rresp  = (s_active && s_beat == err_beat) ? 2'b10 : 2'b00;
      ar_fire = arvalid && arready;
      if (ar_fire) begin
        ar_addr_q = araddr;
        if (n_ar < 16) ar_log[n_ar] = araddr;
        n_ar++;
      end
      r_fire = rvalid && rready;
    end
  end

  always @(negedge clk) begin
    if (reset_n && fifo_wr_en != '0) begin
      if ($countones(fifo_wr_en) != 1) bad_onehot++;
      for (int i = 0; i < NC; i++)
        if (fifo_wr_en[i]) begin
          wr_cnt[i]++;
          if (n_wr < 64) ch_log[n_wr] = i;
        end
      if (n_wr < 64) data_log[n_wr] = fifo_wr_data;
      n_wr++;
    end
  end

  task automatic do_reset();
    reset_n = 0; start = 0; ch_en = '0; ch_wrap_en = '0; fifo_count = '0;
    hold_at = -1; err_beat = -1;
    repeat (2) @(posedge clk);
    #1;
    n_ar = 0; n_wr = 0; bad_onehot = 0;
    for (int i = 0; i < NC; i++) wr_cnt[i] = 0;
    reset_n = 1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  // kind 0: all_done, 1: n_ar >= n, 2: slave sitting at beat n
  task automatic wait_for(input int kind, input int n, output bit ok);
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk); #1;
      case (kind)
        0:       ok = (all_done === 1'b1);
        1:       ok = (n_ar >= n);
        default: ok = s_active && (s_beat == n);
      endcase
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fifo_wr_en !== '0) begin errors++; $display("FAIL reset_wr_en: got %b want 000", fifo_wr_en); end
    checks++; if ({all_done, busy, rd_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {all_done, busy, rd_err}); end
    checks++; if (ch_done !== '0) begin errors++; $display("FAIL reset_ch_done: got %b want 000", ch_done); end
    checks++; if ({arvalid, rready} !== 2'b00 || araddr !== '0) begin errors++; $display("FAIL reset_axi: arvalid=%b rready=%b araddr=%h want 0", arvalid, rready, araddr); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_ar [4] = '{32'h1000, 32'h2000, 32'h3000, 32'h1040};
    bit ok;
    do_reset();
    ch_en = 3'b111;
    ch_start_addr = {32'h3000, 32'h2000, 32'h1000};
    ch_end_addr   = {32'h3040, 32'h2040, 32'h1080};
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy: got %b want 1", busy); end
    wait_for(0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: all_done got %b want 1", all_done); end
    checks++; if (n_ar !== 4) begin errors++; $display("FAIL rr_n_ar: got %0d want 4", n_ar); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ar_log[i] !== exp_ar[i]) begin errors++; $display("FAIL rr_araddr%0d: got %h want %h", i, ar_log[i], exp_ar[i]); end
    end
    checks++; if (n_wr !== 32 || bad_onehot !== 0) begin errors++; $display("FAIL rr_writes: got %0d (bad onehot %0d) want 32 (0)", n_wr, bad_onehot); end
    checks++; if (wr_cnt[0] !== 16 || wr_cnt[1] !== 8 || wr_cnt[2] !== 8) begin errors++; $display("FAIL rr_per_ch: got %0d/%0d/%0d want 16/8/8", wr_cnt[0], wr_cnt[1], wr_cnt[2]); end
    checks++; if (data_log[0] !== 64'h1000 || ch_log[0] !== 0) begin errors++; $display("FAIL rr_first_wr: got %h ch%0d want 1000 ch0", data_log[0], ch_log[0]); end
    checks++; if (data_log[8] !== 64'h2000 || ch_log[8] !== 1) begin errors++; $display("FAIL rr_wr8: got %h ch%0d want 2000 ch1", data_log[8], ch_log[8]); end
    checks++; if (data_log[31] !== 64'h1078 || ch_log[31] !== 0) begin errors++; $display("FAIL rr_last_wr: got %h ch%0d want 1078 ch0", data_log[31], ch_log[31]); end
    checks++; if (ch_done !== 3'b111 || busy !== 1'b0) begin errors++; $display("FAIL rr_end: ch_done=%b busy=%b want 111 0", ch_done, busy); end
  endtask

  task automatic test_ch_en();
    logic [AW-1:0] exp_ar [4] = '{32'h1000, 32'h3000, 32'h1040, 32'h3040};
    bit ok;
    do_reset();
    ch_en = 3'b101;
    ch_start_addr = {32'h3000, 32'h2000, 32'h1000};
    ch_end_addr   = {32'h3080, 32'h2040, 32'h1080};
    pulse_start();
    wait_for(0, 0, ok);
    checks++; if (!ok || n_ar !== 4) begin errors++; $display("FAIL chen_n_ar: got %0d done=%b want 4 1", n_ar, all_done); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ar_log[i] !== exp_ar[i]) begin errors++; $display("FAIL chen_araddr%0d: got %h want %h", i, ar_log[i], exp_ar[i]); end
    end
    checks++; if (wr_cnt[1] !== 0 || ch_done[1] !== 1'b0) begin errors++; $display("FAIL chen_ch1: writes %0d done %b want 0 0", wr_cnt[1], ch_done[1]); end
  endtask

  task automatic test_fifo_space();
    bit ok;
    do_reset();
    ch_en = 3'b011;
    ch_start_addr = {32'h3000, 32'h2000, 32'h1000};
    ch_end_addr   = {32'h3040, 32'h2080, 32'h1040};
    fifo_count[0 +: CW] = 9'd250;
    pulse_start();
    repeat (60) @(posedge clk);
    #1;
    checks++; if (n_ar !== 2 || ar_log[0] !== 32'h2000 || ar_log[1] !== 32'h2040) begin errors++; $display("FAIL space_skip: n_ar %0d first %h second %h want 2 2000 2040", n_ar, ar_log[0], ar_log[1]); end
    checks++; if (busy !== 1'b1 || all_done !== 1'b0) begin errors++; $display("FAIL space_wait: busy %b all_done %b want 1 0", busy, all_done); end
    fifo_count[0 +: CW] = 9'd249;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (n_ar !== 2) begin errors++; $display("FAIL space_249: n_ar %0d want 2", n_ar); end
    fifo_count[0 +: CW] = 9'd248;
    wait_for(0, 0, ok);
    checks++; if (!ok || n_ar !== 3 || ar_log[2] !== 32'h1000) begin errors++; $display("FAIL space_248: n_ar %0d addr %h want 3 1000", n_ar, ar_log[2]); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    ch_en = 3'b001; ch_wrap_en = 3'b001;
    ch_start_addr = {32'h3000, 32'h2000, 32'h1000};
    ch_end_addr   = {32'h3040, 32'h2040, 32'h1080};
    pulse_start();
    wait_for(1, 4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: n_ar %0d want 4", n_ar); end
    checks++; if (ar_log[0] !== 32'h1000 || ar_log[1] !== 32'h1040 || ar_log[2] !== 32'h1000 || ar_log[3] !== 32'h1040) begin errors++; $display("FAIL wrap_seq: got %h %h %h %h want 1000 1040 1000 1040", ar_log[0], ar_log[1], ar_log[2], ar_log[3]); end
    checks++; if (ch_done[0] !== 1'b0 || all_done !== 1'b0) begin errors++; $display("FAIL wrap_done: ch_done0 %b all_done %b want 0 0", ch_done[0], all_done); end
  endtask

  task automatic test_start_mid_burst();
    bit ok;
    do_reset();
    ch_en = 3'b001;
    ch_start_addr = {32'h3000, 32'h2000, 32'h1000};
    ch_end_addr   = {32'h3040, 32'h2040, 32'h1080};
    hold_at = 3;
    pulse_start();
    wait_for(2, 3, ok);
    checks++; if (!ok || n_wr !== 3) begin errors++; $display("FAIL mid_hold: writes %0d want 3", n_wr); end
    ch_start_addr[0 +: AW] = 32'h5000;
    ch_end_addr[0 +: AW]   = 32'h5040;
    pulse_start();
    hold_at = -1;
    wait_for(0, 0, ok);
    checks++; if (!ok || n_ar !== 2 || ar_log[1] !== 32'h5000) begin errors++; $display("FAIL mid_reload_addr: n_ar %0d addr %h want 2 5000", n_ar, ar_log[1]); end
    checks++; if (n_wr !== 11 || data_log[3] !== 64'h5000) begin errors++; $display("FAIL mid_drain: writes %0d wr3 %h want 11 5000", n_wr, data_log[3]); end
  endtask

  task automatic test_degenerate();
    bit ok;
    do_reset();
    ch_en = 3'b111;
    ch_start_addr = {32'h3000, 32'h2000, 32'h1000};
    ch_end_addr   = {32'h2000, 32'h2000, 32'h1040};
    pulse_start();
    checks++; if (ch_done !== 3'b110) begin errors++; $display("FAIL degen_done: got %b want 110", ch_done); end
    wait_for(0, 0, ok);
    checks++; if (!ok || n_ar !== 1 || ch_done !== 3'b111) begin errors++; $display("FAIL degen_end: n_ar %0d ch_done %b want 1 111", n_ar, ch_done); end
  endtask

  task automatic test_err_and_reset();
    bit ok;
    do_reset();
    ch_en = 3'b001;
    ch_start_addr = {32'h3000, 32'h2000, 32'h1000};
    ch_end_addr   = {32'h3040, 32'h2040, 32'h1040};
    err_beat = 4;
    pulse_start();
    wait_for(0, 0, ok);
    checks++; if (!ok || rd_err !== 1'b1) begin errors++; $display("FAIL err_set: rd_err %b want 1", rd_err); end
    checks++; if (n_wr !== 8 || data_log[4] !== 64'h1020) begin errors++; $display("FAIL err_written: writes %0d wr4 %h want 8 1020", n_wr, data_log[4]); end
    err_beat = -1;
    pulse_start();
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL err_clear: rd_err %b want 0", rd_err); end
    wait_for(2, 2, ok);
    checks++; if (!ok || rready !== 1'b1) begin errors++; $display("FAIL rst_midburst_setup: rready %b want 1", rready); end
    reset_n = 0;
    @(posedge clk); #1;
    checks++; if (fifo_wr_en !== '0 || fifo_wr_data !== '0) begin errors++; $display("FAIL rst_mid_wr: en %b data %h want 0 0", fifo_wr_en, fifo_wr_data); end
    checks++; if ({busy, rready, arvalid, all_done} !== 4'b0000 || ch_done !== '0) begin errors++; $display("FAIL rst_mid_state: busy %b rready %b arvalid %b all_done %b ch_done %b want 0", busy, rready, arvalid, all_done, ch_done); end
    reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_ch_en();
    test_fifo_space();
    test_wrap();
    test_start_mid_burst();
    test_degenerate();
    test_err_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
